sram_block_ctrl: RTL and testbench

Initiator-side controller for the on-chip 128-bit block SRAM. It accepts single or burst block requests from a core-side client (cipher datapath, USB buffer logic) and drives the SRAM's read_enable/write_enable/address/write_data pins. It holds each access for the SRAM's fixed latency, captures read data, and returns it through a valid/ready response channel. It is the only block allowed to drive the SRAM bus in the top level.

---
 rtl/sram_block_ctrl_if.sv | 30 +++
 rtl/sram_block_ctrl.sv | 146 ++++++++++++++
 tb/tb_sram_block_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_block_ctrl_if.sv
// rtl/sram_block_ctrl_if.sv - client-side request, write-data, read-response and done signals
interface sram_block_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              done;

  // client side (cipher datapath, USB buffer logic)
  modport master (
    output req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    input  req_ready, wdata_ready, rsp_valid, rsp_rdata, done
  );

  // controller side
  modport slave (
    input  req_valid, req_write, req_addr, req_len, wdata_valid, wdata, rsp_ready,
    output req_ready, wdata_ready, rsp_valid, rsp_rdata, done
  );
endinterface

// File: rtl/sram_block_ctrl.sv
// rtl/sram_block_ctrl.sv - block SRAM initiator: burst FSM, fixed-latency strobes, read capture, write latch
module sram_block_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 128,
  parameter int BLOCK_BYTES = 16,
  parameter int READ_WAIT   = 1,
  parameter int WRITE_WAIT  = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  sram_block_ctrl_if.slave  client,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  // Wait counter compares against the last cycle of each access window.
  localparam logic [2:0]        RD_LAST   = 3'(READ_WAIT - 1);
  localparam logic [2:0]        WR_LAST   = 3'(WRITE_WAIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BLOCK_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_RSP  = 3'd2,
    WR_DATA = 3'd3,
    WR_ACC  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [3:0]        remain_q, remain_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;

  // State and datapath registers; reset aborts any burst and clears the SRAM bus at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  // Next state, wait counting, address stepping, read capture and write-block latch.
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (client.req_valid) begin
          cur_addr_d = client.req_addr;
          remain_d   = client.req_len;
          cnt_d      = '0;
          state_d    = client.req_write ? WR_DATA : RD_ACC;
        end
      end

      RD_ACC: begin
        if (cnt_q == RD_LAST) begin
          rdata_d = sram_rdata;
          cnt_d   = '0;
          state_d = RD_RSP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      RD_RSP: begin
        if (client.rsp_ready) begin
          if (remain_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remain_d   = remain_q - 4'd1;
            cur_addr_d = cur_addr_q + ADDR_STEP;
            cnt_d      = '0;
            state_d    = RD_ACC;
          end
        end
      end

      WR_DATA: begin
        if (client.wdata_valid) begin
          wdata_d = client.wdata;
          cnt_d   = '0;
          state_d = WR_ACC;
        end
      end

      WR_ACC: begin
        if (cnt_q == WR_LAST) begin
          cnt_d = '0;
          if (remain_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remain_d   = remain_q - 4'd1;
            cur_addr_d = cur_addr_q + ADDR_STEP;
            state_d    = WR_DATA;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and handshakes decode from state only, so no client input reaches an SRAM pin.
  assign client.req_ready   = (state_q == IDLE);
  assign client.wdata_ready = (state_q == WR_DATA);
  assign client.rsp_valid   = (state_q == RD_RSP);
  assign client.rsp_rdata   = rdata_q;
  assign client.done        = done_q;
  assign sram_read          = (state_q == RD_ACC);
  assign sram_write         = (state_q == WR_ACC);
  assign sram_addr          = cur_addr_q;
  assign sram_wdata         = wdata_q;

endmodule

// File: tb/tb_sram_block_ctrl.sv
// tb/tb_sram_block_ctrl.sv - self-checking bench: directed table, reset abort, randomized bursts vs memory model
module tb_sram_block_ctrl;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 128;
  localparam int BB     = 16;
  localparam int RW     = 3;
  localparam int WW     = 2;

  logic              clk = 1'b0;
  logic              n_rst = 1'b1;
  logic              sram_read, sram_write;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;

  sram_block_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) c_if ();

  sram_block_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_BYTES(BB),
    .READ_WAIT(RW), .WRITE_WAIT(WW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .client(c_if),
    .sram_read(sram_read), .sram_write(sram_write), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // SRAM device contents and reference memory (block per byte address)
  logic [DATA_W-1:0] mem     [65536];
  logic [DATA_W-1:0] ref_mem [65536];

  assign sram_rdata = mem[sram_addr];

  initial begin : sram_model
    forever begin
      @(posedge clk);
      if (sram_write) mem[sram_addr] = sram_wdata;
    end
  end

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]       addr;
    int                len;
    logic [DATA_W-1:0] data;
  } strb_t;

  strb_t rd_log[$];
  strb_t wr_log[$];

  // Bus monitor: strobe exclusivity, latched-write-data model, strobe logging
  initial begin : monitor
    strb_t rs, ws;
    bit ra, wa;
    logic [DATA_W-1:0] model_wd;
    ra = 0; wa = 0; model_wd = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        ra = 0; wa = 0; model_wd = '0;
      end else begin
        chk1("rd_wr_exclusive", sram_read & sram_write, 1'b0);
        assert (!(sram_read && sram_write));
        chk("sram_wdata_latched", sram_wdata, model_wd);
        if (c_if.wdata_valid && c_if.wdata_ready) model_wd = c_if.wdata;
        if (sram_read) begin
          if (!ra) begin
            ra = 1; rs.addr = sram_addr; rs.len = 1; rs.data = sram_rdata;
          end else begin
            rs.len++;
            chk16("rd_addr_hold", sram_addr, rs.addr);
          end
        end else if (ra) begin
          ra = 0; rd_log.push_back(rs);
        end
        if (sram_write) begin
          if (!wa) begin
            wa = 1; ws.addr = sram_addr; ws.len = 1; ws.data = sram_wdata;
          end else begin
            ws.len++;
            chk16("wr_addr_hold", sram_addr, ws.addr);
          end
        end else if (wa) begin
          wa = 0; wr_log.push_back(ws);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present a request and return just after the edge that accepts it.
  task automatic accept_req(input bit wr, input logic [15:0] a, input logic [3:0] l);
    int n;
    n = 0;
    c_if.req_valid = 1'b1; c_if.req_write = wr; c_if.req_addr = a; c_if.req_len = l;
    @(negedge clk);
    while (!c_if.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("req_accept", c_if.req_ready, 1'b1);
    tick();
    c_if.req_valid = 1'b0;
    c_if.req_write = 1'($urandom);
    c_if.req_addr  = 16'($urandom);
    c_if.req_len   = 4'($urandom);
  endtask

  task automatic finish_burst(input string nm);
    @(negedge clk);
    chk1({nm, "_done"}, c_if.done, 1'b1);
    chk1({nm, "_ready_after"}, c_if.req_ready, 1'b1);
    @(negedge clk);
    chk1({nm, "_done_one_cycle"}, c_if.done, 1'b0);
  endtask

  task automatic run_read(input logic [15:0] a, input logic [3:0] l, input int stall, input logic [15:0] exp_last);
    logic [15:0] ba;
    int k;
    strb_t s;
    accept_req(1'b0, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      ba = a + 16'(b * BB);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!c_if.rsp_valid && k < 50);
      chk_i("rsp_latency", k, RW + 1);
      chk("rsp_data", c_if.rsp_rdata, ref_mem[ba]);
      chk1("req_ready_busy", c_if.req_ready, 1'b0);
      for (int s2 = 0; s2 < stall; s2++) begin
        @(negedge clk);
        chk1("rsp_hold_valid", c_if.rsp_valid, 1'b1);
        chk("rsp_hold_data", c_if.rsp_rdata, ref_mem[ba]);
        chk1("no_read_in_stall", sram_read, 1'b0);
      end
      c_if.rsp_ready = 1'b1;
      tick();
      c_if.rsp_ready = 1'b0;
    end
    finish_burst("rd");
    chk_i("rd_strobe_count", rd_log.size(), int'(l) + 1);
    for (int b = 0; b <= int'(l) && rd_log.size() > 0; b++) begin
      s = rd_log.pop_front();
      chk16("rd_strobe_addr", s.addr, a + 16'(b * BB));
      chk_i("rd_strobe_len", s.len, RW);
      if (b == int'(l)) chk16("rd_last_addr", s.addr, exp_last);
    end
    rd_log.delete();
    tick();
  endtask

  task automatic run_write(input logic [15:0] a, input logic [3:0] l, input int gap, input logic [15:0] exp_last);
    logic [DATA_W-1:0] blk [16];
    int k;
    strb_t s;
    foreach (blk[i]) blk[i] = rnd_blk();
    accept_req(1'b1, a, l);
    for (int b = 0; b <= int'(l); b++) begin
      for (int g = 0; g < gap; g++) begin
        c_if.wdata_valid = 1'b0;
        c_if.wdata = rnd_blk();
        tick();
      end
      c_if.wdata_valid = 1'b1;
      c_if.wdata = blk[b];
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!c_if.wdata_ready && k < 50);
      chk1("wdata_ready", c_if.wdata_ready, 1'b1);
      if (gap == 0 && b > 0) chk_i("wr_block_period", k, WW + 1);
      tick();
      c_if.wdata_valid = (gap == 0);
      c_if.wdata = rnd_blk();
    end
    c_if.wdata_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!c_if.done && k < 50);
    chk_i("wr_done_latency", k, WW + 1);
    chk1("wr_ready_after", c_if.req_ready, 1'b1);
    @(negedge clk);
    chk1("wr_done_one_cycle", c_if.done, 1'b0);
    for (int b = 0; b <= int'(l); b++) ref_mem[a + 16'(b * BB)] = blk[b];
    chk_i("wr_strobe_count", wr_log.size(), int'(l) + 1);
    for (int b = 0; b <= int'(l) && wr_log.size() > 0; b++) begin
      s = wr_log.pop_front();
      chk16("wr_strobe_addr", s.addr, a + 16'(b * BB));
      chk("wr_strobe_data", s.data, blk[b]);
      chk_i("wr_strobe_len", s.len, WW);
      if (b == int'(l)) chk16("wr_last_addr", s.addr, exp_last);
    end
    wr_log.delete();
    tick();
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [3:0]  len;
    int          pace;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    logic [DATA_W-1:0] b0, b1;
    logic [15:0] a, last;
    logic [3:0] l;
    int k;

    vecs[0] = '{1'b1, 16'h0100, 4'd3,  0, 16'h0130};
    vecs[1] = '{1'b0, 16'h0100, 4'd3,  0, 16'h0130};
    vecs[2] = '{1'b0, 16'h0040, 4'd0,  0, 16'h0040};
    vecs[3] = '{1'b0, 16'h0100, 4'd1,  5, 16'h0110};
    vecs[4] = '{1'b1, 16'hFFF0, 4'd1,  4, 16'h0000};
    vecs[5] = '{1'b0, 16'hFFF0, 4'd1,  0, 16'h0000};
    vecs[6] = '{1'b1, 16'h0208, 4'd15, 1, 16'h02F8};
    vecs[7] = '{1'b0, 16'h0208, 4'd15, 2, 16'h02F8};

    foreach (mem[i]) mem[i] = '0;
    foreach (ref_mem[i]) ref_mem[i] = '0;
    mem[16'h0040]     = 128'h00112233445566778899AABBCCDDEEFF;
    ref_mem[16'h0040] = 128'h00112233445566778899AABBCCDDEEFF;

    c_if.req_valid = 1'b0; c_if.req_write = 1'b0; c_if.req_addr = '0; c_if.req_len = '0;
    c_if.wdata_valid = 1'b0; c_if.wdata = '0; c_if.rsp_ready = 1'b0;

    #2 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", c_if.req_ready, 1'b1);
    chk1("rst_wdata_ready", c_if.wdata_ready, 1'b0);
    chk1("rst_rsp_valid", c_if.rsp_valid, 1'b0);
    chk1("rst_done", c_if.done, 1'b0);
    chk1("rst_sram_read", sram_read, 1'b0);
    chk1("rst_sram_write", sram_write, 1'b0);
    chk16("rst_sram_addr", sram_addr, 16'h0000);
    chk("rst_sram_wdata", sram_wdata, '0);
    chk("rst_rsp_rdata", c_if.rsp_rdata, '0);
    #2 n_rst = 1'b1;
    tick();

    // directed table
    foreach (vecs[i]) begin
      if (vecs[i].wr) run_write(vecs[i].addr, vecs[i].len, vecs[i].pace, vecs[i].last);
      else            run_read(vecs[i].addr, vecs[i].len, vecs[i].pace, vecs[i].last);
    end
    chk("preload_read_back", ref_mem[16'h0040], mem[16'h0040]);

    // reset during the second block's write access of a 4-block burst
    b0 = rnd_blk();
    b1 = rnd_blk();
    accept_req(1'b1, 16'h0400, 4'd3);
    c_if.wdata_valid = 1'b1;
    c_if.wdata = b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!c_if.wdata_ready && k < 50);
    tick();
    c_if.wdata = b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!c_if.wdata_ready && k < 50);
    chk1("abort_wready_blk1", c_if.wdata_ready, 1'b1);
    tick();
    c_if.wdata_valid = 1'b0;
    @(negedge clk);
    chk1("abort_in_wr_acc", sram_write, 1'b1);
    chk16("abort_addr_blk1", sram_addr, 16'h0410);
    #1 n_rst = 1'b0;
    #1;
    chk1("abort_write_drops", sram_write, 1'b0);
    chk1("abort_req_ready", c_if.req_ready, 1'b1);
    chk16("abort_addr_cleared", sram_addr, 16'h0000);
    ref_mem[16'h0400] = b0;
    repeat (2) @(posedge clk);
    #3 n_rst = 1'b1;
    wr_log.delete();
    rd_log.delete();
    tick();
    repeat (4) tick();
    chk_i("no_strobe_after_release", wr_log.size() + rd_log.size(), 0);
    chk1("ready_after_release", c_if.req_ready, 1'b1);
    run_read(16'h0000, 4'd0, 0, 16'h0000);
    run_read(16'h0400, 4'd3, 1, 16'h0430);

    // randomized bursts against the reference memory
    for (int i = 0; i < 24; i++) begin
      a = 16'hFE00 + 16'($urandom_range(0, 63) * BB);
      l = 4'($urandom_range(0, 15));
      last = a + (16'(l) << 4);
      if ($urandom_range(0, 1) == 1) run_write(a, l, int'($urandom_range(0, 3)), last);
      else                           run_read(a, l, int'($urandom_range(0, 3)), last);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
